// File: rtl/food_spawner.sv
// Food placement sequencer: samples random words as grid candidates, checks them
// against the occupancy table, and falls back to a wrap-around scan after MAX_TRIES misses.
module food_spawner #(
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int MAX_TRIES = 8,
  localparam int X_BITS   = $clog2(GRID_W),
  localparam int Y_BITS   = $clog2(GRID_H)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              spawn_req,
  input  logic [31:0]       random_number,
  output logic              query_valid,
  output logic [X_BITS-1:0] query_x,
  output logic [Y_BITS-1:0] query_y,
  input  logic              query_occupied,
  output logic [X_BITS-1:0] food_x,
  output logic [Y_BITS-1:0] food_y,
  output logic              food_valid,
  output logic              busy,
  output logic              done,
  output logic              fail
);

  localparam int CELLS  = GRID_W * GRID_H;
  localparam int T_BITS = $clog2(MAX_TRIES + 1);
  localparam int S_BITS = $clog2(CELLS + 1);
  localparam logic [X_BITS:0] GRID_W_L = (X_BITS + 1)'(GRID_W);
  localparam logic [Y_BITS:0] GRID_H_L = (Y_BITS + 1)'(GRID_H);

  typedef enum logic [3:0] {
    S_IDLE, S_SAMPLE, S_CHECK, S_CHECK_WAIT, S_SCAN_INIT,
    S_SCAN_Q, S_SCAN_C, S_DONE, S_FAIL
  } state_t;

  state_t state, state_d;
  logic [T_BITS-1:0] tries, tries_d, tries_inc;
  logic [S_BITS-1:0] scan_cnt, scan_cnt_d, scan_inc;
  logic              have_cand, have_cand_d;
  logic [X_BITS-1:0] cand_x, cand_x_d, query_x_d, food_x_d, cx;
  logic [Y_BITS-1:0] cand_y, cand_y_d, query_y_d, food_y_d, cy;
  logic              query_valid_d, food_valid_d, busy_d, done_d, fail_d;
  logic              in_range, tries_hit, scan_full;
  logic [X_BITS+Y_BITS-1:0] cand_next, query_next;
  logic              unused_rand_bits;

  // Row-major successor with wrap; packed as {y, x}.
  function automatic logic [X_BITS+Y_BITS-1:0] next_cell(input logic [X_BITS-1:0] x,
                                                         input logic [Y_BITS-1:0] y);
    logic [X_BITS-1:0] nx;
    logic [Y_BITS-1:0] ny;
    if (x == X_BITS'(GRID_W - 1)) begin
      nx = '0;
      ny = (y == Y_BITS'(GRID_H - 1)) ? '0 : y + 1'b1;
    end else begin
      nx = x + 1'b1;
      ny = y;
    end
    return {ny, nx};
  endfunction

  assign cx               = random_number[X_BITS-1:0];
  assign cy               = random_number[16 +: Y_BITS];
  assign unused_rand_bits = ^random_number;
  assign in_range         = ({1'b0, cx} < GRID_W_L) && ({1'b0, cy} < GRID_H_L);
  assign tries_inc        = tries + 1'b1;
  assign tries_hit        = (tries_inc == T_BITS'(MAX_TRIES));
  assign scan_inc         = scan_cnt + 1'b1;
  assign scan_full        = (scan_inc == S_BITS'(CELLS));
  assign cand_next        = next_cell(cand_x, cand_y);
  assign query_next       = next_cell(query_x, query_y);

  always_comb begin
    state_d       = state;
    tries_d       = tries;
    scan_cnt_d    = scan_cnt;
    have_cand_d   = have_cand;
    cand_x_d      = cand_x;
    cand_y_d      = cand_y;
    query_valid_d = 1'b0;
    query_x_d     = query_x;
    query_y_d     = query_y;
    food_x_d      = food_x;
    food_y_d      = food_y;
    food_valid_d  = food_valid;
    busy_d        = busy;
    done_d        = 1'b0;
    fail_d        = 1'b0;
    unique case (state)
      S_IDLE: begin
        // busy drops only after the done/fail pulse cycle has been seen.
        busy_d = 1'b0;
        if (spawn_req) begin
          busy_d       = 1'b1;
          food_valid_d = 1'b0;
          tries_d      = '0;
          have_cand_d  = 1'b0;
          state_d      = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (in_range) begin
          query_x_d     = cx;
          query_y_d     = cy;
          query_valid_d = 1'b1;
          cand_x_d      = cx;
          cand_y_d      = cy;
          have_cand_d   = 1'b1;
          state_d       = S_CHECK;
        end else begin
          tries_d = tries_inc;
          state_d = tries_hit ? S_SCAN_INIT : S_SAMPLE;
        end
      end
      S_CHECK: state_d = S_CHECK_WAIT;
      S_CHECK_WAIT: begin
        if (!query_occupied) begin
          food_x_d = cand_x;
          food_y_d = cand_y;
          state_d  = S_DONE;
        end else begin
          tries_d = tries_inc;
          state_d = tries_hit ? S_SCAN_INIT : S_SAMPLE;
        end
      end
      S_SCAN_INIT: begin
        // The lookup is launched here so query_valid is high for the SCAN_Q cycle.
        {query_y_d, query_x_d} = have_cand ? cand_next : '0;
        query_valid_d          = 1'b1;
        scan_cnt_d             = '0;
        state_d                = S_SCAN_Q;
      end
      S_SCAN_Q: state_d = S_SCAN_C;
      S_SCAN_C: begin
        if (!query_occupied) begin
          food_x_d = query_x;
          food_y_d = query_y;
          state_d  = S_DONE;
        end else begin
          scan_cnt_d = scan_inc;
          if (scan_full) begin
            state_d = S_FAIL;
          end else begin
            {query_y_d, query_x_d} = query_next;
            query_valid_d          = 1'b1;
            state_d                = S_SCAN_Q;
          end
        end
      end
      S_DONE: begin
        food_valid_d = 1'b1;
        done_d       = 1'b1;
        state_d      = S_IDLE;
      end
      S_FAIL: begin
        fail_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      tries       <= '0;
      scan_cnt    <= '0;
      have_cand   <= 1'b0;
      cand_x      <= '0;
      cand_y      <= '0;
      query_valid <= 1'b0;
      query_x     <= '0;
      query_y     <= '0;
      food_x      <= '0;
      food_y      <= '0;
      food_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_d;
      tries       <= tries_d;
      scan_cnt    <= scan_cnt_d;
      have_cand   <= have_cand_d;
      cand_x      <= cand_x_d;
      cand_y      <= cand_y_d;
      query_valid <= query_valid_d;
      query_x     <= query_x_d;
      query_y     <= query_y_d;
      food_x      <= food_x_d;
      food_y      <= food_y_d;
      food_valid  <= food_valid_d;
      busy        <= busy_d;
      done        <= done_d;
      fail        <= fail_d;
    end
  end

endmodule

// File: tb/tb_food_spawner.sv
// Scoreboard bench for food_spawner: expected lookups and spawn results are queued
// up front and retired as the DUT issues queries and done/fail pulses.
module tb_food_spawner;
  localparam int GW = 32;
  localparam int GH = 24;
  localparam int XB = 5;
  localparam int YB = 5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          spawn_req = 1'b0;
  logic [31:0]   random_number = '0;
  logic          query_occupied = 1'b1;
  logic          query_valid, food_valid, busy, done, fail;
  logic [XB-1:0] query_x, food_x;
  logic [YB-1:0] query_y, food_y;

  food_spawner #(.GRID_W(GW), .GRID_H(GH), .MAX_TRIES(8)) dut (
    .clock(clock), .reset_n(reset_n), .spawn_req(spawn_req),
    .random_number(random_number), .query_valid(query_valid),
    .query_x(query_x), .query_y(query_y), .query_occupied(query_occupied),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .busy(busy), .done(done), .fail(fail)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit            is_fail;
    logic [XB-1:0] x;
    logic [YB-1:0] y;
  } res_t;

  int checks = 0;
  int failures = 0;
  logic [GW-1:0]     occ_map [GH];
  logic [31:0]       rand_q [$];
  logic [XB+YB-1:0]  exp_q [$];
  res_t              exp_res [$];
  logic              pend_v = 1'b0;
  logic              pend_occ = 1'b0;
  int cyc = 0, spawn_cyc = 0, ev_cyc = 0;
  int qcount = 0, done_cnt = 0, fail_cnt = 0;
  bit ev_seen = 0;

  function automatic logic [31:0] word_of(input int x, input int y);
    return (32'(y) << 16) | 32'(x);
  endfunction

  // One clock: answer lookups one cycle late, retire queries and results.
  task automatic step();
    logic [XB+YB-1:0] e;
    res_t r;
    @(posedge clock);
    #1;
    cyc++;
    query_occupied = pend_v ? pend_occ : 1'b1;
    pend_v = 1'b0;
    if (query_valid) begin
      qcount++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL query_unexpected got=(%0d,%0d) none expected", query_x, query_y);
      end else begin
        e = exp_q.pop_front();
        if ({query_y, query_x} !== e) begin
          failures++;
          $display("FAIL query_cell got=(%0d,%0d) exp=(%0d,%0d)",
                   query_x, query_y, e[XB-1:0], e[XB+YB-1:XB]);
        end
      end
      pend_occ = occ_map[query_y][query_x];
      pend_v = 1'b1;
      if (rand_q.size() > 0) begin
        void'(rand_q.pop_front());
        if (rand_q.size() > 0) random_number = rand_q[0];
      end
    end
    if (done || fail) begin
      ev_seen = 1;
      ev_cyc = cyc;
      if (done) done_cnt++;
      if (fail) fail_cnt++;
      checks++;
      if (exp_res.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected got done=%0b fail=%0b", done, fail);
      end else begin
        r = exp_res.pop_front();
        if ({done, fail, food_valid} !== (r.is_fail ? 3'b010 : 3'b101)) begin
          failures++;
          $display("FAIL result_kind got done/fail/valid=%b exp=%b",
                   {done, fail, food_valid}, (r.is_fail ? 3'b010 : 3'b101));
        end
        checks++;
        if ({food_x, food_y} !== {r.x, r.y}) begin
          failures++;
          $display("FAIL result_food got=(%0d,%0d) exp=(%0d,%0d)", food_x, food_y, r.x, r.y);
        end
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_at_pulse got=%0b exp=1", busy);
        end
      end
    end
  endtask

  task automatic wait_event(input int budget, input string name);
    int n = 0;
    while (!ev_seen && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (!ev_seen) begin
      failures++;
      $display("FAIL %s_timeout got=no done/fail after %0d cycles exp=pulse", name, budget);
    end
  endtask

  task automatic spawn();
    ev_seen = 0;
    spawn_req = 1'b1;
    step();
    spawn_req = 1'b0;
    spawn_cyc = cyc;
  endtask

  task automatic set_occ(input logic fill);
    for (int r = 0; r < GH; r++) occ_map[r] = fill ? '1 : '0;
  endtask

  task automatic check_idle_after(input string name, input logic exp_fv);
    step();
    checks++;
    if ({busy, food_valid} !== {1'b0, exp_fv}) begin
      failures++;
      $display("FAIL %s_idle got busy/valid=%b exp=%b", name, {busy, food_valid}, {1'b0, exp_fv});
    end
    checks++;
    if (exp_q.size() != 0 || exp_res.size() != 0) begin
      failures++;
      $display("FAIL %s_pending got queries=%0d results=%0d exp=0/0", name, exp_q.size(), exp_res.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) step();
    checks++;
    if ({query_valid, query_x, query_y, food_x, food_y, food_valid, busy, done, fail} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0",
               {query_valid, query_x, query_y, food_x, food_y, food_valid, busy, done, fail});
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    set_occ(1'b0);
    qcount = 0;
    random_number = 32'h0005_0003;
    exp_q.push_back({5'd5, 5'd3});
    exp_res.push_back('{1'b0, 5'd3, 5'd5});
    spawn();
    wait_event(20, "single");
    checks++;
    if (ev_cyc - spawn_cyc != 4) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=4", ev_cyc - spawn_cyc);
    end
    check_idle_after("single", 1'b1);
  endtask

  task automatic test_reject();
    set_occ(1'b0);
    qcount = 0;
    random_number = 32'h001E_0003;
    exp_q.push_back({5'd2, 5'd7});
    exp_res.push_back('{1'b0, 5'd7, 5'd2});
    spawn();
    repeat (2) step();
    random_number = 32'h0002_0007;
    wait_event(30, "reject");
    checks++;
    if (qcount != 1) begin
      failures++;
      $display("FAIL reject_qcount got=%0d exp=1", qcount);
    end
    check_idle_after("reject", 1'b1);
  endtask

  task automatic test_scan_fallback();
    set_occ(1'b0);
    qcount = 0;
    for (int i = 0; i < 7; i++) begin
      rand_q.push_back(word_of(i, i));
      occ_map[i][i] = 1'b1;
      exp_q.push_back({5'(i), 5'(i)});
    end
    rand_q.push_back(word_of(31, 23));
    occ_map[23][31] = 1'b1;
    exp_q.push_back({5'd23, 5'd31});
    for (int x = 1; x < 4; x++) occ_map[0][x] = 1'b1;
    for (int x = 0; x <= 4; x++) exp_q.push_back({5'd0, 5'(x)});
    exp_res.push_back('{1'b0, 5'd4, 5'd0});
    random_number = rand_q[0];
    spawn();
    wait_event(200, "scan");
    checks++;
    if (qcount != 13) begin
      failures++;
      $display("FAIL scan_qcount got=%0d exp=13", qcount);
    end
    check_idle_after("scan", 1'b1);
  endtask

  task automatic test_all_full();
    int x, y;
    set_occ(1'b1);
    qcount = 0;
    done_cnt = 0;
    fail_cnt = 0;
    x = 0;
    y = 0;
    for (int i = 0; i < 8; i++) begin
      x = $urandom_range(0, GW - 1);
      y = $urandom_range(0, GH - 1);
      rand_q.push_back(word_of(x, y));
      exp_q.push_back({5'(y), 5'(x)});
    end
    for (int i = 0; i < GW * GH; i++) begin
      x = x + 1;
      if (x == GW) begin
        x = 0;
        y = (y == GH - 1) ? 0 : y + 1;
      end
      exp_q.push_back({5'(y), 5'(x)});
    end
    exp_res.push_back('{1'b1, 5'd4, 5'd0});
    random_number = rand_q[0];
    spawn();
    wait_event(3000, "full");
    checks++;
    if (qcount != 8 + GW * GH || done_cnt != 0 || fail_cnt != 1) begin
      failures++;
      $display("FAIL full_counts got q=%0d done=%0d fail=%0d exp q=776 done=0 fail=1",
               qcount, done_cnt, fail_cnt);
    end
    check_idle_after("full", 1'b0);
  endtask

  task automatic test_back_to_back();
    set_occ(1'b0);
    qcount = 0;
    done_cnt = 0;
    random_number = 32'h0014_000A;
    exp_q.push_back({5'd20, 5'd10});
    exp_res.push_back('{1'b0, 5'd10, 5'd20});
    ev_seen = 0;
    spawn_req = 1'b1;
    repeat (5) step();
    spawn_req = 1'b0;
    wait_event(20, "b2b");
    repeat (10) step();
    checks++;
    if (done_cnt != 1 || qcount != 1) begin
      failures++;
      $display("FAIL b2b_counts got done=%0d q=%0d exp done=1 q=1", done_cnt, qcount);
    end
    check_idle_after("b2b", 1'b1);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    set_occ(1'b1);
    qcount = 0;
    random_number = 32'h001F_0000;
    for (int x = 0; x < 6; x++) exp_q.push_back({5'd0, 5'(x)});
    spawn();
    while (qcount < 3 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (qcount != 3 || query_valid !== 1'b1) begin
      failures++;
      $display("FAIL midreset_reach got q=%0d qv=%0b exp q=3 qv=1", qcount, query_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({query_valid, query_x, query_y, food_x, food_y, food_valid, busy, done, fail} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b exp=0",
               {query_valid, query_x, query_y, food_x, food_y, food_valid, busy, done, fail});
    end
    exp_q.delete();
    exp_res.delete();
    pend_v = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    test_single();
  endtask

  initial begin
    test_reset();
    test_single();
    test_reject();
    test_scan_fallback();
    test_all_full();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
